mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one W-bit N:1 multiplexer path between N requesters. It holds a one-hot grant and drives the shared mux select from a registered owner index. It also presents the selected requester's data on a single output port. It sits in front of the shared mux datapath and is the only block allowed to drive its select.

## Interface
Parameters:
- N, 4, number of requesters (≥2, power of two)
- W, 8, data width per requester
- MAX_BURST, 4, max consecutive granted cycles per owner when burst limiting is compiled in (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  per-requester request; level, held while data is to be passed
- din  input  N*W  requester data, slice i = din[i*W +: W]
- gnt  output  N  one-hot grant, registered; all-zero when idle
- sel  output  $clog2(N)  registered owner index; drives the shared mux select
- dout  output  W  din slice for sel when any gnt bit is set, else 0
- dout_valid  output  1  high when gnt[sel] && req[sel]

## Operation
- Two states: IDLE (no owner) and GRANT (owner = sel).
- Pick function: the first requester with req set, searched from ptr upward with wrap (ptr, ptr+1, …, N-1, 0, …).
- IDLE:
  - If req ≠ 0 → GRANT; owner = pick; gnt = one-hot(owner); sel = owner.
  - Otherwise remain in IDLE with gnt = 0.
- GRANT, owner still requesting (req[sel] = 1): hold gnt and sel unchanged.
- GRANT, owner released (req[sel] = 0):
  - ptr ← sel+1 mod N.
  - Pick from the new ptr, excluding the old owner.
  - If another requester is pending → new owner, stay in GRANT.
  - If none is pending → IDLE with gnt = 0.
- Handoff happens in a single edge with no idle bubble cycle.
- ptr only advances on release or forced release. It does not change in IDLE.
- dout and dout_valid are combinational from the registered sel/gnt and from live req/din. They never select a non-owner.
- Requests appearing and vanishing in the same IDLE cycle are not latched. Only the value sampled at the edge counts.

## Timing
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - State IDLE, gnt = 0, sel = 0, ptr = 0, burst count = 0.
  - Resulting outputs: dout = 0, dout_valid = 0.
- Reset asserted mid-grant: gnt drops to 0 immediately, with no wait for a clock edge.
- Grant latency: a req sampled high at edge k gives gnt high after edge k (visible in cycle k+1).
- Release latency: the owner's req sampled low at edge k means the new gnt (or zero) is valid after edge k.
- Simultaneous requests: resolved purely by rotating priority from ptr.
- Wrap: with ptr = N-1 and requests from N-1 and 0, N-1 wins. After it releases, ptr = 0.

## Configuration
- ARB_BURST_LIMIT_EN defined:
  - An up-counter counts granted cycles of the current owner. It clears on every owner change and in IDLE.
  - When the count reaches MAX_BURST and another requester is pending, the grant is forcibly released at that edge, as if the owner's req were low. ptr ← sel+1 and the next owner is picked.
  - If no other requester is pending, the owner keeps the grant and the count saturates at MAX_BURST.
- ARB_BURST_LIMIT_EN undefined: no counter is built and an owner holds the grant for as long as its req stays high.

## Structure
- Shared package mux_arb_pkg holds:
  - state enum (ARB_IDLE, ARB_GRANT)
  - default parameter constants (N, W, MAX_BURST)
  - a localparam for the select width.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req, ptr, exclude-mask.
  - Outputs: found flag and index.
- The arbiter instantiates it once and contains the state, pointer, counter and output registers.

## Test plan
- Reset, then req = 0100 at edge 3:
  - gnt = 0100 and sel = 2 after edge 3.
  - dout = din slice 2, dout_valid = 1.
- req = 1111 held from reset; each owner drops its req for one cycle after its first grant cycle:
  - grant order 0,1,2,3,0 with no zero-gnt cycle between owners.
- req = 0011 at reset; owner 0 releases:
  - gnt moves 0001→0010 on the same edge; ptr = 1.
  - Owner 1 releases with req = 0000 → IDLE, gnt = 0, dout = 0.
- With ARB_BURST_LIMIT_EN and MAX_BURST = 4:
  - req = 0011 held → owner 0 granted 4 cycles, then owner 1 granted 4 cycles, alternating.
  - req = 0001 held → owner 0 is never released.
- rst_n pulsed low mid-grant (gnt = 1000):
  - gnt = 0 and dout_valid = 0 immediately.
  - After release, req = 1000 → regranted one edge later with ptr = 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding,
// default parameter values and the default select width.
package mux_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int N_DEF         = 4;
    localparam int W_DEF         = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int SEL_W_DEF     = $clog2(N_DEF);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first requester that is
// requesting and not excluded, searching from ptr upward with wrap-around.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SEL_W_DEF
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [SW-1:0] idx_o
);

    logic [N-1:0]  elig;
    logic [SW-1:0] cand;

    assign elig = req_i & ~excl_i;

    // Walk ptr, ptr+1, ... modulo N (N is a power of two, so the SW-bit add wraps)
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_i + SW'(i);
            if (!found_o && elig[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared W-bit N:1 mux.
// Holds a registered one-hot grant and owner index; the owner keeps the
// grant while it requests, and handoff to the next requester takes one edge.
// Optional burst limiting is compiled in with the ARB_BURST_LIMIT_EN macro.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int W         = W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         dout,
    output logic                 dout_valid
);

    localparam int SW = $clog2(N);

    if ((N < 2) || ((N & (N - 1)) != 0) || (MAX_BURST < 1)) begin : g_param_check
        $error("mux_rr_arbiter: N must be a power of two >= 2 and MAX_BURST >= 1");
    end

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] pick_ptr;
    logic [N-1:0]  pick_excl;
    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic          owner_rel;
    logic          load_new;
    logic          burst_hit;

`ifdef ARB_BURST_LIMIT_EN
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    // Holds the number of granted cycles of the current owner, counting the present one
    logic [CW-1:0] cnt_q, cnt_d;

    assign burst_hit = (cnt_q == CNT_MAX);
`else
    assign burst_hit = 1'b0;
`endif

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .excl_i  (pick_excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Next-state: grant from IDLE, hold while owner requests, hand off on (forced) release
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        pick_ptr  = ptr_q;
        pick_excl = '0;
        owner_rel = 1'b0;
        load_new  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d  = ARB_GRANT;
                    sel_d    = pick_idx;
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    load_new = 1'b1;
                end else begin
                    gnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // Search as if the pointer had already moved past the owner
                pick_ptr  = sel_q + SW'(1);
                pick_excl = {{(N-1){1'b0}}, 1'b1} << sel_q;
                owner_rel = !req[sel_q] || (burst_hit && pick_found);
                if (owner_rel) begin
                    ptr_d = sel_q + SW'(1);
                    if (pick_found) begin
                        sel_d    = pick_idx;
                        gnt_d    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        load_new = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

`ifdef ARB_BURST_LIMIT_EN
    // Burst counter: restart at 1 on a new owner, saturate at MAX_BURST, clear in IDLE
    always_comb begin
        cnt_d = '0;
        if (state_d == ARB_GRANT) begin
            if (load_new) begin
                cnt_d = CW'(1);
            end else if (burst_hit) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Burst counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // State, grant, owner and pointer registers; reset drops the grant at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = (|gnt_q) ? din[sel_q*W +: W] : '0;
    assign dout_valid = gnt_q[sel_q] & req[sel_q];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8).
// Burst-limit scenarios are compiled when ARB_BURST_LIMIT_EN is defined.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic           dout_valid;

    int n_vec = 0;
    int n_err = 0;

    mux_rr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        rst_n = 1'b0;
        #2;
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_vec++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid: got %b want 0", dout_valid); end
        n_vec++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        tick();
        tick();
        req = 4'b0100;
        #1;
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_pre_gnt: got %b want 0000", gnt); end
        n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL single_pre_dout: got %h want 00", dout); end
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        n_vec++; if (sel !== 2'd2) begin n_err++; $display("FAIL single_sel: got %0d want 2", sel); end
        n_vec++; if (dout !== 8'hA2) begin n_err++; $display("FAIL single_dout: got %h want a2", dout); end
        n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL single_dvalid: got %b want 1", dout_valid); end
        req = 4'b0000;
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
        n_vec++; if (dut.ptr_q !== 2'd3) begin n_err++; $display("FAIL single_ptr: got %0d want 3", dut.ptr_q); end
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_now;
        logic [N-1:0] exp_next;
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_now  = 4'b0001 << k;
            exp_next = 4'b0001 << ((k + 1) % 4);
            n_vec++; if (gnt !== exp_now) begin n_err++; $display("FAIL rot_first%0d: got %b want %b", k, gnt, exp_now); end
            req = 4'b1111;
            tick();
            n_vec++; if (gnt !== exp_now) begin n_err++; $display("FAIL rot_hold%0d: got %b want %b", k, gnt, exp_now); end
            req = ~exp_now;
            tick();
            n_vec++; if (gnt !== exp_next) begin n_err++; $display("FAIL rot_handoff%0d: got %b want %b", k, gnt, exp_next); end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b0011;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ho_first_gnt: got %b want 0001", gnt); end
        req = 4'b0010;
        #1;
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ho_rel_dvalid: got %b want 0", dout_valid); end
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL ho_gnt: got %b want 0010", gnt); end
        n_vec++; if (dut.ptr_q !== 2'd1) begin n_err++; $display("FAIL ho_ptr: got %0d want 1", dut.ptr_q); end
        n_vec++; if (dout !== 8'hA1) begin n_err++; $display("FAIL ho_dout: got %h want a1", dout); end
        req = 4'b0000;
        #1;
        n_vec++; if (dout !== 8'hA1) begin n_err++; $display("FAIL ho_pending_dout: got %h want a1", dout); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ho_pending_dvalid: got %b want 0", dout_valid); end
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ho_idle_gnt: got %b want 0000", gnt); end
        n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL ho_idle_dout: got %h want 00", dout); end
        n_vec++; if (dut.ptr_q !== 2'd2) begin n_err++; $display("FAIL ho_idle_ptr: got %0d want 2", dut.ptr_q); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        n_vec++; if (dut.ptr_q !== 2'd3) begin n_err++; $display("FAIL wrap_ptr3: got %0d want 3", dut.ptr_q); end
        req = 4'b1001;
        tick();
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_gnt: got %b want 1000", gnt); end
        n_vec++; if (sel !== 2'd3) begin n_err++; $display("FAIL wrap_sel: got %0d want 3", sel); end
        req = 4'b0001;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_next_gnt: got %b want 0001", gnt); end
        n_vec++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL wrap_ptr0: got %0d want 0", dut.ptr_q); end
    endtask

    task automatic test_no_latch();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL nolatch_gnt: got %b want 0000", gnt); end
        n_vec++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL nolatch_ptr: got %0d want 0", dut.ptr_q); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1000;
        tick();
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL rmg_gnt: got %b want 1000", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rmg_async_gnt: got %b want 0000", gnt); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rmg_async_dvalid: got %b want 0", dout_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL rmg_regrant: got %b want 1000", gnt); end
        n_vec++; if (dut.ptr_q !== 2'd0) begin n_err++; $display("FAIL rmg_ptr: got %0d want 0", dut.ptr_q); end
        n_vec++; if (dout !== 8'hA3) begin n_err++; $display("FAIL rmg_dout: got %h want a3", dout); end
    endtask

`ifdef ARB_BURST_LIMIT_EN
    task automatic test_burst();
        logic [N-1:0] exp_g;
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < 16; c++) begin
            exp_g = (((c / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
            n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL burst_alt%0d: got %b want %b", c, gnt, exp_g); end
            tick();
        end
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 10; c++) begin
            n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL burst_solo%0d: got %b want 0001", c, gnt); end
            tick();
        end
    endtask
`else
    task automatic test_hold();
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < 10; c++) begin
            n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL hold%0d: got %b want 0001", c, gnt); end
            tick();
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) din[i*W +: W] = 8'(8'hA0 + i);
        test_reset();
        test_single();
        test_rotation();
        test_handoff();
        test_wrap();
        test_no_latch();
        test_reset_mid_grant();
`ifdef ARB_BURST_LIMIT_EN
        test_burst();
`else
        test_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
